// File: rtl/lifegame_seq.sv
// Generation sequencer for a WIDTH x HEIGHT toroidal life grid held in a two-bank row memory.
// Streams 3x3 windows to an external cell unit and writes each new row to the opposite bank.
module lifegame_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  localparam int unsigned RW    = $clog2(HEIGHT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       run_gens,
  input  logic              stop,
  output logic              rd_en,
  output logic [RW:0]       rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              wr_en,
  output logic [RW:0]       wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic [8:0]        neibor,
  output logic              cal_enable,
  input  logic              cal_out,
  output logic              busy,
  output logic              gen_done,
  output logic [15:0]       gen_count,
  output logic              cur_bank
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    IDLE, L0, L1, L2, L3, CALC, DRAIN, WRITE, GEN_END
  } state_t;

  state_t             state;
  logic [RW-1:0]      row;
  logic [CW-1:0]      col;
  logic [15:0]        gens_target;
  logic [WIDTH-1:0]   row_p, row_c, row_n;
  logic [WIDTH-2:0]   newrow;

  function automatic logic [RW-1:0] row_dec(input logic [RW-1:0] r);
    return (r == '0) ? RW'(HEIGHT - 1) : r - 1'b1;
  endfunction

  function automatic logic [RW-1:0] row_inc(input logic [RW-1:0] r);
    return (r == RW'(HEIGHT - 1)) ? '0 : r + 1'b1;
  endfunction

  // 3x3 toroidal window around column k: rows above/centre/below, each {c-1, c, c+1}
  function automatic logic [8:0] window(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] c,
                                        input logic [WIDTH-1:0] n, input logic [CW-1:0] k);
    logic [CW-1:0] km, kp;
    km = (k == '0) ? CW'(WIDTH - 1) : k - 1'b1;
    kp = (k == CW'(WIDTH - 1)) ? '0 : k + 1'b1;
    return {p[km], p[k], p[kp], c[km], c[k], c[kp], n[km], n[k], n[kp]};
  endfunction

  // Outputs are registered on the transition into the state that owns them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      gens_target <= '0;
      row_p       <= '0;
      row_c       <= '0;
      row_n       <= '0;
      newrow      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      neibor      <= '0;
      cal_enable  <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
      gen_count   <= '0;
      cur_bank    <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      cal_enable <= 1'b0;
      gen_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            gens_target <= run_gens;
            gen_count   <= '0;
            row         <= '0;
            busy        <= 1'b1;
            rd_en       <= 1'b1;
            rd_addr     <= {cur_bank, row_dec('0)};
            state       <= L0;
          end
        end
        L0: begin
          rd_en   <= 1'b1;
          rd_addr <= {cur_bank, row};
          state   <= L1;
        end
        L1: begin
          row_p   <= rd_data;
          rd_en   <= 1'b1;
          rd_addr <= {cur_bank, row_inc(row)};
          state   <= L2;
        end
        L2: begin
          row_c <= rd_data;
          state <= L3;
        end
        L3: begin
          row_n      <= rd_data;
          neibor     <= window(row_p, row_c, rd_data, '0);
          cal_enable <= 1'b1;
          col        <= '0;
          state      <= CALC;
        end
        CALC: begin
          if (col != '0) newrow[col - 1'b1] <= cal_out;
          if (col != CW'(WIDTH - 1)) begin
            col        <= col + 1'b1;
            cal_enable <= 1'b1;
            neibor     <= window(row_p, row_c, row_n, col + 1'b1);
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          wr_en   <= 1'b1;
          wr_addr <= {~cur_bank, row};
          wr_data <= {cal_out, newrow};
          state   <= WRITE;
        end
        WRITE: begin
          if (row != RW'(HEIGHT - 1)) begin
            row     <= row + 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= {cur_bank, row};
            state   <= L0;
          end else begin
            gen_done  <= 1'b1;
            cur_bank  <= ~cur_bank;
            gen_count <= (gen_count == 16'hFFFF) ? gen_count : gen_count + 16'd1;
            state     <= GEN_END;
          end
        end
        GEN_END: begin
          // gen_count already holds the count including this generation
          if ((gens_target != '0 && gen_count == gens_target) || stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            row     <= '0;
            rd_en   <= 1'b1;
            rd_addr <= {cur_bank, row_dec('0)};
            state   <= L0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
